ps2_mouse_ctrl: RTL and testbench
=================================

# ps2_mouse_ctrl

PS/2 mouse host sequencer that sits between the `ps2rx`/`ps2tx` byte engines and the cursor/display logic. It runs the mouse initialisation handshake (reset, BAT, ID, enable streaming), with per-step timeouts, resend handling and bounded retries. It then assembles synchronised 3-byte stream packets into one-cycle `pkt_valid` strobes carrying signed 9-bit deltas.

## Interface

Parameters:
- `INIT_TIMEOUT`, default 12_500_000: cycles allowed per init step before a retry.
- `PKT_TIMEOUT`, default 50_000: max cycles between bytes within one packet.
- `MAX_RETRY`, default 3: init attempts before giving up.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset; synchronous, active-high.
- `restart`  in  1: pulse; re-run init from scratch and clear the retry count.
- `tx_wr`  out  1: write request to `ps2tx`.
- `tx_din`  out  8: command byte.
- `tx_done_tick`  in  1: `ps2tx` finished sending the byte.
- `rx_done_tick`  in  1: `ps2rx` byte strobe.
- `rx_dout`  in  8: received byte.
- `ready`  out  1: high while in a STREAM state.
- `fail`  out  1: high in FAILED.
- `pkt_valid`  out  1: one-cycle packet strobe.
- `pkt_btn`  out  3: {middle, right, left}.
- `pkt_dx`, `pkt_dy`  out  9: two's-complement deltas.
- `pkt_ovf`  out  2: {y_ovf, x_ovf}.

## Operation

States: SEND_RST, ACK_RST, WAIT_BAT, WAIT_ID, SEND_EN, ACK_EN, STREAM0, STREAM1, STREAM2, FAILED.

- **SEND_RST:** `tx_wr`=1, `tx_din`=8'hFF. On `tx_done_tick` go to ACK_RST.
- **SEND_EN:** `tx_wr`=1, `tx_din`=8'hF4. On `tx_done_tick` go to ACK_EN.
- **Outside SEND states:** `tx_wr`=0 and `tx_din`=0.
- **ACK_RST / ACK_EN:**
  - 8'hFA advances to WAIT_BAT / STREAM0 respectively.
  - 8'hFE returns to the matching SEND state (a resend); this counts as a retry.
  - Any other byte is ignored.
- **WAIT_BAT:** 8'hAA advances to WAIT_ID. 8'hFC is a retry event. Other bytes are ignored.
- **WAIT_ID:** 8'h00 advances to SEND_EN. Any other byte is a retry event.
- **Init timeout:** in any init state (SEND_RST through ACK_EN), a step timer reaching `INIT_TIMEOUT` is a retry event.
- **Retry event:**
  - Increment `retry_cnt` (width `$clog2(MAX_RETRY+1)`) and go to SEND_RST.
  - If `retry_cnt` would reach `MAX_RETRY`, go to FAILED instead.
  - FE-triggered resends also increment the count but go to the SEND state rather than SEND_RST.
- **STREAM0:** a byte with bit3=1 is latched as b0; go to STREAM1. A byte with bit3=0 is discarded (resync) and the state stays STREAM0.
- **STREAM1:** latch b1; go to STREAM2.
- **STREAM2:** on the byte, register the outputs, pulse `pkt_valid`, and go to STREAM0. Output fields:
  - `pkt_btn`=b0[2:0]
  - `pkt_dx`={b0[4],b1}
  - `pkt_dy`={b0[5],byte}
  - `pkt_ovf`=b0[7:6]
- **Inter-byte timeout:** in STREAM1/STREAM2, the timer reaching `PKT_TIMEOUT` drops the partial packet and returns to STREAM0. No strobe is issued.
- **FAILED:** holds until `restart` or `rst`.
- **`restart`** (any state): `retry_cnt`=0, go to SEND_RST next cycle. It has priority over all other events in that cycle.
- `pkt_*` fields hold their values until the next packet completes.

## Timing

- **Reset values:**
  - state SEND_RST, `retry_cnt`=0, timer=0.
  - `tx_wr` rises on the first cycle after `rst` deasserts, because SEND_RST is the reset state.
  - All other outputs are 0.
- **Step timer:**
  - Clears on every state change and on every `rx_done_tick`.
  - Otherwise increments, saturating.
  - Timeout fires on the cycle where timer == limit-1.
- **Packet latency:** `pkt_valid` is high exactly one cycle, the cycle after the `rx_done_tick` of byte 3. `pkt_*` update in that same cycle.
- **Event priority:**
  - `rx_done_tick` is ignored in SEND states; only `tx_done_tick` matters there.
  - A byte and a timeout in the same cycle: the byte wins.
- **Mid-operation reset:** `rst` or `restart` during SEND drops `tx_wr` the next cycle, then reasserts it in SEND_RST.
- **Output timing:** `ready`/`fail` are decoded from registered state, with no combinational path from inputs.

## Test plan

- **Happy path:**
  - Stimulus: ack `tx_done` for FF; bytes FA, AA, 00; ack F4; byte FA; then packet 0x29, 0x05, 0xFE.
  - Required response: `ready`=1; one `pkt_valid` with `pkt_btn`=3'b001, `pkt_dx`=+5, `pkt_dy`=9'h1FE (−2 with b0[5]=1), `pkt_ovf`=0.
- **Resend:** byte FE in ACK_EN → `tx_wr` reasserts with `tx_din`=F4; `retry_cnt`=1; then FA → `ready`.
- **Timeout to FAILED:** no responses with `INIT_TIMEOUT`=100, `MAX_RETRY`=3 → three SEND_RST attempts, then `fail`=1 and `tx_wr`=0. `restart` → `tx_wr`=1 with `tx_din`=FF.
- **Resync:** in stream, bytes 0x00, 0x08, 0x10, 0x20 → 0x00 discarded; one packet with `pkt_dx`=0x010 and `pkt_dy`=0x020.
- **Inter-byte timeout:** 0x08, 0x01, then `PKT_TIMEOUT` idle, then 0x08, 0x02, 0x03 → single packet with `pkt_dx`=2, `pkt_dy`=3.
- **Same-cycle events:** `rst` mid-packet → no `pkt_valid`, outputs cleared. Byte and timeout coincident in ACK_RST with FA → advances to WAIT_BAT.

Source files
------------

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse host sequencer: runs reset/BAT/ID/enable init with retries, then
// assembles synchronised 3-byte stream packets into one-cycle strobes.
module ps2_mouse_ctrl #(
  parameter int INIT_TIMEOUT = 12_500_000,
  parameter int PKT_TIMEOUT  = 50_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  output logic       tx_wr,
  output logic [7:0] tx_din,
  input  logic       tx_done_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  output logic       ready,
  output logic       fail,
  output logic       pkt_valid,
  output logic [2:0] pkt_btn,
  output logic [8:0] pkt_dx,
  output logic [8:0] pkt_dy,
  output logic [1:0] pkt_ovf
);

  localparam int TMAX = (INIT_TIMEOUT > PKT_TIMEOUT) ? INIT_TIMEOUT : PKT_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    SEND_RST, ACK_RST, WAIT_BAT, WAIT_ID, SEND_EN, ACK_EN,
    STREAM0, STREAM1, STREAM2, FAILED
  } state_t;

  state_t          r_state, w_next, w_resendTo;
  logic [RW-1:0]   r_retryCnt, w_retryNext;
  logic [TW-1:0]   r_timer;
  logic            r_txEn;
  logic [7:0]      r_b0, r_b1;
  logic            r_pktValid;
  logic [2:0]      r_pktBtn;
  logic [8:0]      r_pktDx, r_pktDy;
  logic [1:0]      r_pktOvf;
  logic            w_initTo, w_pktTo, w_retryEv, w_resend, w_clrTimer;
  logic            w_b0Load, w_b1Load, w_pktLoad;

  assign w_initTo = (r_timer == TW'(INIT_TIMEOUT - 1));
  assign w_pktTo  = (r_timer == TW'(PKT_TIMEOUT - 1));

  // r_txEn is low for the first cycle after rst/restart so tx_wr visibly drops
  // before the reset command is re-issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= SEND_RST;
      r_retryCnt <= '0;
      r_timer    <= '0;
      r_txEn     <= 1'b0;
      r_b0       <= '0;
      r_b1       <= '0;
      r_pktValid <= 1'b0;
      r_pktBtn   <= '0;
      r_pktDx    <= '0;
      r_pktDy    <= '0;
      r_pktOvf   <= '0;
    end else begin
      r_state    <= w_next;
      r_retryCnt <= w_retryNext;
      r_txEn     <= !restart;
      if (w_clrTimer)
        r_timer <= '0;
      else if (r_timer != '1)
        r_timer <= r_timer + TW'(1);
      if (w_b0Load)
        r_b0 <= rx_dout;
      if (w_b1Load)
        r_b1 <= rx_dout;
      r_pktValid <= w_pktLoad;
      if (w_pktLoad) begin
        r_pktBtn <= r_b0[2:0];
        r_pktDx  <= {r_b0[4], r_b1};
        r_pktDy  <= {r_b0[5], rx_dout};
        r_pktOvf <= r_b0[7:6];
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_retryNext = r_retryCnt;
    w_retryEv   = 1'b0;
    w_resend    = 1'b0;
    w_resendTo  = SEND_RST;
    w_b0Load    = 1'b0;
    w_b1Load    = 1'b0;
    w_pktLoad   = 1'b0;
    case (r_state)
      SEND_RST: if (r_txEn) begin
        if (tx_done_tick)  w_next = ACK_RST;
        else if (w_initTo) w_retryEv = 1'b1;
      end
      ACK_RST: if (rx_done_tick) begin
        if (rx_dout == 8'hFA) w_next = WAIT_BAT;
        else if (rx_dout == 8'hFE) begin
          w_resend   = 1'b1;
          w_resendTo = SEND_RST;
        end
      end else if (w_initTo) w_retryEv = 1'b1;
      WAIT_BAT: if (rx_dout == 8'hAA && rx_done_tick) w_next = WAIT_ID;
        else if (rx_dout == 8'hFC && rx_done_tick)   w_retryEv = 1'b1;
        else if (!rx_done_tick && w_initTo)           w_retryEv = 1'b1;
      WAIT_ID: if (rx_done_tick) begin
        if (rx_dout == 8'h00) w_next = SEND_EN;
        else                  w_retryEv = 1'b1;
      end else if (w_initTo) w_retryEv = 1'b1;
      SEND_EN: if (r_txEn) begin
        if (tx_done_tick)  w_next = ACK_EN;
        else if (w_initTo) w_retryEv = 1'b1;
      end
      ACK_EN: if (rx_done_tick) begin
        if (rx_dout == 8'hFA) w_next = STREAM0;
        else if (rx_dout == 8'hFE) begin
          w_resend   = 1'b1;
          w_resendTo = SEND_EN;
        end
      end else if (w_initTo) w_retryEv = 1'b1;
      // Bytes without the always-one bit 3 cannot start a packet: resync.
      STREAM0: if (rx_done_tick && rx_dout[3]) begin
        w_b0Load = 1'b1;
        w_next   = STREAM1;
      end
      STREAM1: if (rx_done_tick) begin
        w_b1Load = 1'b1;
        w_next   = STREAM2;
      end else if (w_pktTo) w_next = STREAM0;
      STREAM2: if (rx_done_tick) begin
        w_pktLoad = 1'b1;
        w_next    = STREAM0;
      end else if (w_pktTo) w_next = STREAM0;
      FAILED: w_next = FAILED;
      default: w_next = SEND_RST;
    endcase
    if (w_retryEv || w_resend) begin
      w_retryNext = r_retryCnt + RW'(1);
      if (r_retryCnt == RW'(MAX_RETRY - 1)) w_next = FAILED;
      else                                  w_next = w_retryEv ? SEND_RST : w_resendTo;
    end
    if (restart) begin
      w_next      = SEND_RST;
      w_retryNext = '0;
      w_pktLoad   = 1'b0;
    end
    w_clrTimer = rx_done_tick || restart || !r_txEn || w_retryEv || w_resend ||
                 (w_next != r_state);
  end

  always_comb begin
    tx_wr  = 1'b0;
    tx_din = 8'h00;
    if (r_txEn) begin
      if (r_state == SEND_RST) begin
        tx_wr  = 1'b1;
        tx_din = 8'hFF;
      end else if (r_state == SEND_EN) begin
        tx_wr  = 1'b1;
        tx_din = 8'hF4;
      end
    end
  end

  assign ready     = (r_state == STREAM0) || (r_state == STREAM1) || (r_state == STREAM2);
  assign fail      = (r_state == FAILED);
  assign pkt_valid = r_pktValid;
  assign pkt_btn   = r_pktBtn;
  assign pkt_dx    = r_pktDx;
  assign pkt_dy    = r_pktDy;
  assign pkt_ovf   = r_pktOvf;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Self-checking bench for ps2_mouse_ctrl: table-driven init/stream vectors plus
// directed sequences for resend, coincident events, reset and retry exhaustion.
module tb_ps2_mouse_ctrl;

  localparam int INIT_TO = 100;
  localparam int PKT_TO  = 40;
  localparam int OP_RX   = 0;
  localparam int OP_ACK  = 1;
  localparam int OP_IDLE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  logic       tx_wr;
  logic [7:0] tx_din;
  logic       tx_done_tick = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic       ready, fail, pkt_valid;
  logic [2:0] pkt_btn;
  logic [8:0] pkt_dx, pkt_dy;
  logic [1:0] pkt_ovf;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         op;
    logic [7:0] data;
    int         cycles;
    logic       eWr;
    logic [7:0] eDin;
    logic       eReady;
    logic       eFail;
    logic       eValid;
    logic       chkPkt;
    logic [2:0] eBtn;
    logic [8:0] eDx;
    logic [8:0] eDy;
    logic [1:0] eOvf;
  } vec_t;

  vec_t tbl[$];

  ps2_mouse_ctrl #(.INIT_TIMEOUT(INIT_TO), .PKT_TIMEOUT(PKT_TO), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .tx_wr(tx_wr), .tx_din(tx_din), .tx_done_tick(tx_done_tick),
    .rx_done_tick(rx_done_tick), .rx_dout(rx_dout),
    .ready(ready), .fail(fail), .pkt_valid(pkt_valid),
    .pkt_btn(pkt_btn), .pkt_dx(pkt_dx), .pkt_dy(pkt_dy), .pkt_ovf(pkt_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) step();
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic rxByte(input logic [7:0] b);
    rx_dout = b;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    rx_dout = 8'h00;
  endtask

  task automatic txAck();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    case (v.op)
      OP_RX:   rxByte(v.data);
      OP_ACK:  txAck();
      default: tick(v.cycles);
    endcase
  endtask

  function automatic void rec(input int op, input logic [7:0] d, input int n,
                              input logic wr, input logic [7:0] din, input logic rdy,
                              input logic vld, input logic chk, input logic [2:0] btn,
                              input logic [8:0] dx, input logic [8:0] dy, input logic [1:0] ovf);
    vec_t v;
    v = '{op, d, n, wr, din, rdy, 1'b0, vld, chk, btn, dx, dy, ovf};
    tbl.push_back(v);
  endfunction

  task automatic doReset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    step();
  endtask

  task automatic initToAckEn();
    txAck();
    rxByte(8'hFA);
    rxByte(8'hAA);
    rxByte(8'h00);
    txAck();
  endtask

  initial begin
    // Init handshake, happy-path packet, resync and inter-byte timeout.
    rec(OP_ACK,  8'h00, 0,      1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'hFA, 0,      1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'hAA, 0,      1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'h00, 0,      1'b1, 8'hF4, 1'b0, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_ACK,  8'h00, 0,      1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'hFA, 0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'h29, 0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'h05, 0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'hFE, 0,      1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'b001, 9'h005, 9'h1FE, 2'd0);
    rec(OP_IDLE, 8'h00, 1,      1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'b001, 9'h005, 9'h1FE, 2'd0);
    rec(OP_RX,   8'h00, 0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'h08, 0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'h10, 0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'h20, 0,      1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 9'h010, 9'h020, 2'd0);
    rec(OP_RX,   8'h08, 0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'h01, 0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_IDLE, 8'h00, PKT_TO, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'h08, 0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'h02, 0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 9'h000, 2'd0);
    rec(OP_RX,   8'h03, 0,      1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 9'h002, 9'h003, 2'd0);

    rst = 1'b1;
    tick(3);
    checkOutput("rst.txwr",  tx_wr, 1'b0);
    checkOutput("rst.ready", ready, 1'b0);
    checkOutput("rst.fail",  fail, 1'b0);
    checkOutput("rst.valid", pkt_valid, 1'b0);
    checkOutput("rst.dx",    pkt_dx, 9'h000);
    rst = 1'b0;
    step();
    checkOutput("rel.txwr", tx_wr, 1'b1);
    checkOutput("rel.din",  tx_din, 8'hFF);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("v%0d.txwr", i),  tx_wr, tbl[i].eWr);
      checkOutput($sformatf("v%0d.din", i),   tx_din, tbl[i].eDin);
      checkOutput($sformatf("v%0d.ready", i), ready, tbl[i].eReady);
      checkOutput($sformatf("v%0d.fail", i),  fail, tbl[i].eFail);
      checkOutput($sformatf("v%0d.valid", i), pkt_valid, tbl[i].eValid);
      if (tbl[i].chkPkt) begin
        checkOutput($sformatf("v%0d.btn", i), pkt_btn, tbl[i].eBtn);
        checkOutput($sformatf("v%0d.dx", i),  pkt_dx, tbl[i].eDx);
        checkOutput($sformatf("v%0d.dy", i),  pkt_dy, tbl[i].eDy);
        checkOutput($sformatf("v%0d.ovf", i), pkt_ovf, tbl[i].eOvf);
      end
    end

    // rst in the middle of a packet: the final byte arrives while rst is high.
    rxByte(8'h08);
    rxByte(8'h01);
    rst = 1'b1;
    rxByte(8'h02);
    checkOutput("midrst.valid", pkt_valid, 1'b0);
    checkOutput("midrst.dx",    pkt_dx, 9'h000);
    checkOutput("midrst.dy",    pkt_dy, 9'h000);
    checkOutput("midrst.ready", ready, 1'b0);
    checkOutput("midrst.txwr",  tx_wr, 1'b0);
    rst = 1'b0;
    step();
    checkOutput("midrst.rel", tx_wr, 1'b1);

    // Resend request in ACK_EN.
    initToAckEn();
    rxByte(8'hFE);
    checkOutput("resend.txwr", tx_wr, 1'b1);
    checkOutput("resend.din",  tx_din, 8'hF4);
    checkOutput("resend.cnt",  dut.r_retryCnt, 2'd1);
    txAck();
    rxByte(8'hFA);
    checkOutput("resend.ready", ready, 1'b1);

    // FA arrives on the very cycle the ACK_RST timeout would fire.
    doReset();
    txAck();
    tick(INIT_TO - 1);
    rxByte(8'hFA);
    checkOutput("coin.txwr", tx_wr, 1'b0);
    checkOutput("coin.cnt",  dut.r_retryCnt, 2'd0);
    rxByte(8'hAA);
    rxByte(8'h00);
    checkOutput("coin.txwr2", tx_wr, 1'b1);
    checkOutput("coin.din",   tx_din, 8'hF4);

    // Silent mouse: three SEND_RST attempts of INIT_TO cycles, then FAILED.
    doReset();
    checkOutput("to.start", tx_wr, 1'b1);
    tick(3 * INIT_TO - 1);
    checkOutput("to.txwr",  tx_wr, 1'b1);
    checkOutput("to.fail0", fail, 1'b0);
    checkOutput("to.cnt",   dut.r_retryCnt, 2'd2);
    step();
    checkOutput("to.fail1", fail, 1'b1);
    checkOutput("to.txwr0", tx_wr, 1'b0);
    checkOutput("to.din0",  tx_din, 8'h00);
    tick(20);
    checkOutput("to.hold", fail, 1'b1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    checkOutput("rs.fail", fail, 1'b0);
    checkOutput("rs.drop", tx_wr, 1'b0);
    step();
    checkOutput("rs.txwr", tx_wr, 1'b1);
    checkOutput("rs.din",  tx_din, 8'hFF);
    checkOutput("rs.cnt",  dut.r_retryCnt, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
